byte_lane_scheduler: RTL and testbench

BYTE_LANE_SCHEDULER -- requirements
Module: byte_lane_scheduler

---
 rtl/lane_symbols_pkg.sv | 22 ++
 rtl/skp_timer.sv | 27 ++
 rtl/byte_lane_scheduler.sv | 115 +++++++++++
 tb/tb_byte_lane_scheduler.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/lane_symbols_pkg.sv
// Lane symbol constants shared with the existing generators, plus the scheduler
// state encoding and a small burst-counter helper.
package lane_symbols_pkg;

  localparam logic [7:0] COM = 8'hbc;
  localparam logic [7:0] SKP = 8'h1c;
  localparam logic [7:0] STP = 8'hfb;
  localparam logic [7:0] SDP = 8'h5c;
  localparam logic [7:0] END = 8'hfd;
  localparam logic [7:0] IDL = 8'h7c;

  typedef enum logic [1:0] {
    START = 2'd0,
    RUN   = 2'd1,
    SKIP  = 2'd2
  } sched_state_e;

  function automatic logic [3:0] burst_sat_inc(input logic [3:0] cnt, input logic [3:0] max);
    return (cnt >= max) ? max : cnt + 4'd1;
  endfunction

endpackage

// File: rtl/skp_timer.sv
// Free-running SKP interval counter; wrap_o is high in the last cycle of each
// interval. Only instantiated when BYTE_LANE_SCHEDULER_SKP_INSERT_EN is defined.
module skp_timer #(
  parameter int SKP_INTERVAL = 16
) (
  input  logic clk,
  input  logic reset,
  output logic wrap_o
);

  localparam logic [7:0] LAST = 8'(SKP_INTERVAL - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = (cnt_q == LAST) ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= 8'd0;
    else       cnt_q <= cnt_d;
  end

  assign wrap_o = (cnt_q == LAST);

endmodule

// File: rtl/byte_lane_scheduler.sv
// Two-source byte lane scheduler with burst-limited arbitration and a COM header.
// Optional periodic SKP insertion is enabled by BYTE_LANE_SCHEDULER_SKP_INSERT_EN.
//
// Handshake: a source byte is accepted in a cycle where readyN and valid_inN are
// both 1; ready is combinational, never high for an idle source, and at most one
// ready is high. The accepted byte appears on data_out/valid_out one cycle later.
module byte_lane_scheduler
  import lane_symbols_pkg::*;
#(
  parameter int SKP_INTERVAL = 16,
  parameter int MAX_BURST    = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         valid_in0,
  input  logic [7:0]   data_in0,
  input  logic         valid_in1,
  input  logic [7:0]   data_in1,
  output logic         ready0,
  output logic         ready1,
  output logic         valid_out,
  output logic [7:0]   data_out,
  output sched_state_e state_dbg
);

  localparam logic [3:0] MAX_B = 4'(MAX_BURST);

  sched_state_e state_q, state_d;
  logic         valid_out_q, valid_out_d;
  logic [7:0]   data_out_q, data_out_d;
  logic         last_q, last_d;
  logic [3:0]   burst_q, burst_d;

  logic any_req;
  logic stay;
  logic winner;

`ifdef BYTE_LANE_SCHEDULER_SKP_INSERT_EN
  logic skp_wrap;

  skp_timer #(
    .SKP_INTERVAL(SKP_INTERVAL)
  ) u_skp_timer (
    .clk    (clk),
    .reset  (reset),
    .wrap_o (skp_wrap)
  );
`endif

  // burst_q == 0 means nothing granted since reset, so a tie goes to source 0.
  always_comb begin
    any_req = valid_in0 | valid_in1;
    stay    = (burst_q != 4'd0) && (burst_q < MAX_B);
    if (valid_in0 && valid_in1) winner = stay ? last_q : ~last_q;
    else                        winner = valid_in1;
  end

  assign ready0 = (state_q == RUN) && valid_in0 && !winner;
  assign ready1 = (state_q == RUN) && valid_in1 && winner;

  always_comb begin
    state_d     = state_q;
    valid_out_d = 1'b0;
    data_out_d  = IDL;
    last_d      = last_q;
    burst_d     = burst_q;
    case (state_q)
      START: begin
        valid_out_d = 1'b1;
        data_out_d  = COM;
        state_d     = RUN;
      end
      RUN: begin
        if (any_req) begin
          valid_out_d = 1'b1;
          data_out_d  = winner ? data_in1 : data_in0;
          last_d      = winner;
          burst_d     = (winner == last_q) ? burst_sat_inc(burst_q, MAX_B) : 4'd1;
        end
`ifdef BYTE_LANE_SCHEDULER_SKP_INSERT_EN
        if (skp_wrap) state_d = SKIP;
`endif
      end
`ifdef BYTE_LANE_SCHEDULER_SKP_INSERT_EN
      SKIP: begin
        valid_out_d = 1'b1;
        data_out_d  = SKP;
        state_d     = RUN;
      end
`endif
      default: state_d = START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= START;
      valid_out_q <= 1'b0;
      data_out_q  <= IDL;
      last_q      <= 1'b1;
      burst_q     <= 4'd0;
    end else begin
      state_q     <= state_d;
      valid_out_q <= valid_out_d;
      data_out_q  <= data_out_d;
      last_q      <= last_d;
      burst_q     <= burst_d;
    end
  end

  assign valid_out = valid_out_q;
  assign data_out  = data_out_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_byte_lane_scheduler.sv
// Bench for byte_lane_scheduler (SKP_INTERVAL=8, MAX_BURST=4); follows
// BYTE_LANE_SCHEDULER_SKP_INSERT_EN to decide whether SKP symbols are expected.
module tb_byte_lane_scheduler;
  import lane_symbols_pkg::*;

  localparam int SKP_INTERVAL = 8;
  localparam int MAX_BURST    = 4;
`ifdef BYTE_LANE_SCHEDULER_SKP_INSERT_EN
  localparam bit SKP_ON = 1'b1;
`else
  localparam bit SKP_ON = 1'b0;
`endif

  // clock / reset
  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         valid_in0 = 1'b0;
  logic [7:0]   data_in0 = 8'h00;
  logic         valid_in1 = 1'b0;
  logic [7:0]   data_in1 = 8'h00;
  logic         ready0, ready1, valid_out;
  logic [7:0]   data_out;
  sched_state_e state_dbg;

  always #5 clk = ~clk;

  byte_lane_scheduler #(
    .SKP_INTERVAL(SKP_INTERVAL),
    .MAX_BURST   (MAX_BURST)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in0 (valid_in0),
    .data_in0  (data_in0),
    .valid_in1 (valid_in1),
    .data_in1  (data_in1),
    .ready0    (ready0),
    .ready1    (ready1),
    .valid_out (valid_out),
    .data_out  (data_out),
    .state_dbg (state_dbg)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard and sources
  logic [8:0] exp_q[$];
  logic [7:0] src0_q[$];
  logic [7:0] src1_q[$];
  bit         hold0, hold1;
  int         pct = 100;

  // reference model: slot index since COM, last grant and its run length
  bit m_started;
  int m_slot;
  bit m_last;
  int m_run;
  int skp_exp, skp_seen;
  bit log_grants = 1'b0;
  bit grant_log[$];

  task automatic tick();
    logic       er0, er1, w;
    logic [8:0] e;
    if (!hold0 && src0_q.size() > 0 && $urandom_range(99) < pct) hold0 = 1'b1;
    if (!hold1 && src1_q.size() > 0 && $urandom_range(99) < pct) hold1 = 1'b1;
    valid_in0 = hold0;
    data_in0  = hold0 ? src0_q[0] : 8'($urandom);
    valid_in1 = hold1;
    data_in1  = hold1 ? src1_q[0] : 8'($urandom);
    @(negedge clk);
    er0 = 1'b0;
    er1 = 1'b0;
    w   = 1'b0;
    e   = {1'b0, IDL};
    if (!m_started) begin
      e = {1'b1, COM};
      m_started = 1'b1;
      m_slot = 1;
    end else if (SKP_ON && (m_slot % SKP_INTERVAL == 0)) begin
      e = {1'b1, SKP};
      m_slot++;
      skp_exp++;
    end else begin
      if (valid_in0 && valid_in1) w = (m_run > 0 && m_run < MAX_BURST) ? m_last : !m_last;
      else                        w = valid_in1;
      if (valid_in0 || valid_in1) begin
        er0 = !w;
        er1 = w;
        e = {1'b1, (w ? data_in1 : data_in0)};
        m_run = (w == m_last) ? m_run + 1 : 1;
        m_last = w;
      end
      m_slot++;
    end
    chk("ready0", ready0, er0);
    chk("ready1", ready1, er1);
    chk("ready_excl", ready0 & ready1, 0);
    if (log_grants && (ready0 || ready1)) grant_log.push_back(ready1);
    if (valid_in0 && ready0) begin void'(src0_q.pop_front()); hold0 = 1'b0; end
    if (valid_in1 && ready1) begin void'(src1_q.pop_front()); hold1 = 1'b0; end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("valid_out", valid_out, e[8]);
    chk("data_out", data_out, e[7:0]);
    if (valid_out && data_out == SKP) skp_seen++;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_until_empty(input int bound);
    int i;
    i = 0;
    while ((src0_q.size() > 0 || src1_q.size() > 0) && i < bound) begin
      tick();
      i++;
    end
    chk("drain_left", src0_q.size() + src1_q.size(), 0);
  endtask

  // asserts reset asynchronously, checks the forced outputs, releases after an edge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    valid_in0 = 1'b0;
    valid_in1 = 1'b0;
    hold0 = 1'b0;
    hold1 = 1'b0;
    src0_q.delete();
    src1_q.delete();
    #1;
    chk({tag, "_valid"}, valid_out, 0);
    chk({tag, "_data"}, data_out, IDL);
    chk({tag, "_ready0"}, ready0, 0);
    chk({tag, "_ready1"}, ready1, 0);
    chk({tag, "_state"}, state_dbg, START);
    @(posedge clk);
    #1;
    reset = 1'b0;
    m_started = 1'b0;
    m_slot = 0;
    m_last = 1'b1;
    m_run = 0;
  endtask

  initial begin
    #1;
    do_reset("rst0");
    pct = 100;
    run_n(6);

    do_reset("rst1");
    src0_q.push_back(8'h11);
    src0_q.push_back(8'h22);
    src0_q.push_back(8'h33);
    run_until_empty(20);
    run_n(2);

    do_reset("rst2");
    for (int i = 0; i < 16; i++) begin
      src0_q.push_back(8'(8'h40 + i));
      src1_q.push_back(8'(8'h80 + i));
    end
    grant_log.delete();
    log_grants = 1'b1;
    run_until_empty(80);
    log_grants = 1'b0;
    chk("grant_cnt", grant_log.size(), 32);
    for (int i = 0; i < 12; i++) chk("grant_seq", grant_log[i], (i / MAX_BURST) % 2);

    do_reset("rst3");
    skp_seen = 0;
    skp_exp = 0;
    for (int i = 0; i < 30; i++) src0_q.push_back(8'(8'h20 + i));
    run_until_empty(100);
    chk("skp_count", skp_seen, skp_exp);

    do_reset("rst4");
    pct = 50;
    for (int i = 0; i < 60; i++) begin
      src0_q.push_back(8'($urandom));
      src1_q.push_back(8'($urandom));
    end
    run_until_empty(600);
    run_n(3);
    pct = 25;
    for (int i = 0; i < 40; i++) begin
      src0_q.push_back(8'($urandom));
      src1_q.push_back(8'($urandom));
    end
    run_until_empty(600);

    do_reset("rst5");
    pct = 100;
    for (int i = 0; i < 10; i++) src1_q.push_back(8'(8'ha0 + i));
    run_n(5);
    #2;
    do_reset("rst_mid");
    run_n(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
